// File: rtl/song_mem_responder_if.sv
// Song-fetch read bus, loader write bus and sticky address-error flag for song_mem_responder.
interface song_mem_responder_if;
    logic        memreq_val;
    logic [15:0] memreq_addr;
    logic        memresp_wait;
    logic [31:0] memresp_data;
    logic        prog_val;
    logic [15:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_rdy;
    logic        addr_err;

    modport master (
        output memreq_val, memreq_addr, prog_val, prog_addr, prog_data,
        input  memresp_wait, memresp_data, prog_rdy, addr_err
    );

    modport slave (
        input  memreq_val, memreq_addr, prog_val, prog_addr, prog_data,
        output memresp_wait, memresp_data, prog_rdy, addr_err
    );
endinterface

// File: rtl/song_mem_responder.sv
// Song memory responder: note-word storage with configurable read stall and a loader write port.
// Optional SONG_MEM_STATS_EN adds a saturating served-read counter on rd_count.
module song_mem_responder #(
    parameter int NUM_SONGS      = 4,
    parameter int WORDS_PER_SONG = 128,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                clk,
    input  logic                rst,
    song_mem_responder_if.slave bus
`ifdef SONG_MEM_STATS_EN
    ,
    output logic [15:0]         rd_count
`endif
);

    localparam int         DEPTH      = NUM_SONGS * WORDS_PER_SONG;
    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [6:0] SONG_LIMIT = 7'(NUM_SONGS);
    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
    localparam bit         HAS_WAIT   = (WAIT_CYCLES != 0);
    localparam bit         ONE_WAIT   = (WAIT_CYCLES == 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SERVE} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        prev_val;
    logic [15:0] prev_addr;
    logic        addr_err_q;
    logic [31:0] mem [DEPTH];

    logic             req_active;
    logic             new_req;
    logic             resp_wait;
    logic             rd_in_range;
    logic             rd_misaligned;
    logic             wr_in_range;
    logic             wr_misaligned;
    logic             wr_fire;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      rd_word;

    // Reset masks the request so outputs fall to zero while rst is held.
    assign req_active    = bus.memreq_val & ~rst;
    assign new_req       = req_active & (~prev_val | (bus.memreq_addr != prev_addr));
    assign resp_wait     = HAS_WAIT & (new_req | (state == ST_WAIT));
    assign rd_in_range   = bus.memreq_addr[15:9] < SONG_LIMIT;
    assign rd_misaligned = |bus.memreq_addr[1:0];
    assign wr_in_range   = bus.prog_addr[15:9] < SONG_LIMIT;
    assign wr_misaligned = |bus.prog_addr[1:0];
    assign rd_idx        = bus.memreq_addr[IDX_W+1:2];
    assign wr_idx        = bus.prog_addr[IDX_W+1:2];
    assign wr_fire       = bus.prog_val & bus.prog_rdy;

    assign bus.memresp_wait = resp_wait;
    assign bus.prog_rdy     = (state != ST_WAIT);
    assign bus.addr_err     = addr_err_q;

    always_comb begin
        rd_word          = rd_in_range ? mem[rd_idx] : 32'hFFFF_FFFF;
        bus.memresp_data = 32'h0;
        if (req_active && !resp_wait) begin
            bus.memresp_data = rd_word;
        end
    end

    // A new request spends its first stall cycle while the FSM is still IDLE/SERVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'h0;
            prev_val   <= 1'b0;
            prev_addr  <= 16'h0;
            addr_err_q <= 1'b0;
        end else begin
            prev_val  <= bus.memreq_val;
            prev_addr <= bus.memreq_addr;
            if ((bus.memreq_val && (!rd_in_range || rd_misaligned)) ||
                (wr_fire && (!wr_in_range || wr_misaligned))) begin
                addr_err_q <= 1'b1;
            end
            if (new_req) begin
                if (!HAS_WAIT || ONE_WAIT) begin
                    state <= ST_SERVE;
                end else begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
            end else if (!bus.memreq_val) begin
                state <= ST_IDLE;
            end else if (state == ST_WAIT) begin
                if (wait_cnt <= 4'd1) begin
                    state <= ST_SERVE;
                end
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Storage is deliberately unreset so preloaded songs survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range) begin
            mem[wr_idx] <= bus.prog_data;
        end
    end

`ifdef SONG_MEM_STATS_EN
    logic served_flag;
    logic served_now;

    assign served_now = req_active & ~resp_wait & (new_req | ~served_flag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count    <= 16'h0;
            served_flag <= 1'b0;
        end else begin
            served_flag <= req_active & (served_now | (served_flag & ~new_req));
            if (served_now && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_song_mem_responder.sv
// Bench for song_mem_responder: one zero-wait and one two-wait instance against an associative-array model.
module tb_song_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    song_mem_responder_if ifc0 ();
    song_mem_responder_if ifc2 ();

`ifdef SONG_MEM_STATS_EN
    logic [15:0] rd_count0;
    logic [15:0] rd_count2;
`endif

    song_mem_responder #(.NUM_SONGS(4), .WORDS_PER_SONG(128), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0)
`ifdef SONG_MEM_STATS_EN
        , .rd_count(rd_count0)
`endif
    );

    song_mem_responder #(.NUM_SONGS(4), .WORDS_PER_SONG(128), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(ifc2)
`ifdef SONG_MEM_STATS_EN
        , .rd_count(rd_count2)
`endif
    );

    int compared = 0;
    int mismatched = 0;
    int rd_exp0 = 0;
    int rd_exp2 = 0;
    logic [31:0] model0 [logic [13:0]];
    logic [31:0] model2 [logic [13:0]];
    logic [15:0] addrs0 [$];
    logic [15:0] addrs2 [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_all();
        ifc0.memreq_val = 1'b0; ifc0.prog_val = 1'b0;
        ifc2.memreq_val = 1'b0; ifc2.prog_val = 1'b0;
    endtask

    task automatic prog0(input logic [15:0] a, input logic [31:0] d);
        ifc0.prog_val = 1'b1; ifc0.prog_addr = a; ifc0.prog_data = d;
        sample();
        compared++;
        if (ifc0.prog_rdy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL prog0_rdy: got %b expected 1", ifc0.prog_rdy);
        end
        tick();
        ifc0.prog_val = 1'b0;
        if (a[15:9] < 7'd4) model0[a[15:2]] = d;
    endtask

    task automatic prog2(input logic [15:0] a, input logic [31:0] d);
        ifc2.prog_val = 1'b1; ifc2.prog_addr = a; ifc2.prog_data = d;
        sample();
        compared++;
        if (ifc2.prog_rdy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL prog2_rdy: got %b expected 1", ifc2.prog_rdy);
        end
        tick();
        ifc2.prog_val = 1'b0;
        if (a[15:9] < 7'd4) model2[a[15:2]] = d;
    endtask

    task automatic test_rd_count(input string name);
`ifdef SONG_MEM_STATS_EN
        compared += 2;
        if (rd_count0 !== 16'(rd_exp0)) begin
            mismatched++;
            $display("[TB] FAIL %s rd_count0: got %0d expected %0d", name, rd_count0, rd_exp0);
        end
        if (rd_count2 !== 16'(rd_exp2)) begin
            mismatched++;
            $display("[TB] FAIL %s rd_count2: got %0d expected %0d", name, rd_count2, rd_exp2);
        end
`else
        $display("[TB] %s: rd_count not built", name);
`endif
    endtask

    task automatic test_reset();
        idle_all();
        ifc0.memreq_addr = '0; ifc0.prog_addr = '0; ifc0.prog_data = '0;
        ifc2.memreq_addr = '0; ifc2.prog_addr = '0; ifc2.prog_data = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        sample();
        compared += 8;
        if (ifc0.memresp_wait !== 1'b0 || ifc2.memresp_wait !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_wait: got %b/%b expected 0/0", ifc0.memresp_wait, ifc2.memresp_wait);
        end
        if (ifc0.memresp_data !== 32'h0) begin
            mismatched++; $display("[TB] FAIL reset_data0: got %h expected 0", ifc0.memresp_data);
        end
        if (ifc2.memresp_data !== 32'h0) begin
            mismatched++; $display("[TB] FAIL reset_data2: got %h expected 0", ifc2.memresp_data);
        end
        if (ifc0.prog_rdy !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_rdy0: got %b expected 1", ifc0.prog_rdy);
        end
        if (ifc2.prog_rdy !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_rdy2: got %b expected 1", ifc2.prog_rdy);
        end
        if (ifc0.addr_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_err0: got %b expected 0", ifc0.addr_err);
        end
        if (ifc2.addr_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_err2: got %b expected 0", ifc2.addr_err);
        end
        if (ifc2.memresp_wait !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_wait2: got %b expected 0", ifc2.memresp_wait);
        end
        test_rd_count("reset");
        tick();
    endtask

    task automatic test_zero_wait();
        logic [15:0] rd_addrs [2];
        logic [31:0] exp;
        prog0(16'h0000, 32'd3);
        prog0(16'h0004, 32'd1);
        rd_addrs[0] = 16'h0000; rd_addrs[1] = 16'h0004;
        ifc0.memreq_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifc0.memreq_addr = rd_addrs[i];
            exp = model0[rd_addrs[i][15:2]];
            sample();
            compared += 2;
            if (ifc0.memresp_wait !== 1'b0) begin
                mismatched++; $display("[TB] FAIL zero_wait_wait: got %b expected 0", ifc0.memresp_wait);
            end
            if (ifc0.memresp_data !== exp) begin
                mismatched++; $display("[TB] FAIL zero_wait_data: got %h expected %h", ifc0.memresp_data, exp);
            end
            rd_exp0++;
            tick();
        end
        ifc0.memreq_val = 1'b0;
        sample();
        compared++;
        if (ifc0.memresp_data !== 32'h0) begin
            mismatched++; $display("[TB] FAIL zero_wait_idle_data: got %h expected 0", ifc0.memresp_data);
        end
        tick();
    endtask

    task automatic test_random_zero_wait();
        logic [15:0] a;
        logic [15:0] last;
        bit          held;
        for (int i = 0; i < 16; i++) begin
            a = {7'($urandom_range(1, 2)), 7'($urandom_range(0, 127)), 2'b00};
            prog0(a, $urandom);
            addrs0.push_back(a);
        end
        held = 1'b0; last = '0;
        for (int i = 0; i < 20; i++) begin
            a = addrs0[$urandom_range(0, addrs0.size() - 1)];
            if (held && a == last) begin
                ifc0.memreq_val = 1'b0;
                tick();
            end
            ifc0.memreq_val = 1'b1; ifc0.memreq_addr = a;
            sample();
            compared++;
            if (ifc0.memresp_wait !== 1'b0 || ifc0.memresp_data !== model0[a[15:2]]) begin
                mismatched++;
                $display("[TB] FAIL rand0 @%h: got wait %b data %h expected wait 0 data %h", a, ifc0.memresp_wait, ifc0.memresp_data, model0[a[15:2]]);
            end
            rd_exp0++;
            tick();
            held = 1'b1; last = a;
        end
        ifc0.memreq_val = 1'b0;
        tick();
        test_rd_count("rand0");
    endtask

    task automatic test_wait_timing();
        logic [31:0] exp;
        prog2(16'h0600, 32'd5);
        ifc2.memreq_val = 1'b1; ifc2.memreq_addr = 16'h0600;
        for (int k = 0; k < 4; k++) begin
            exp = (k < 2) ? 32'h0 : 32'd5;
            sample();
            compared += 2;
            if (ifc2.memresp_wait !== (k < 2)) begin
                mismatched++; $display("[TB] FAIL wait_timing_wait k=%0d: got %b expected %b", k, ifc2.memresp_wait, k < 2);
            end
            if (ifc2.memresp_data !== exp) begin
                mismatched++; $display("[TB] FAIL wait_timing_data k=%0d: got %h expected %h", k, ifc2.memresp_data, exp);
            end
            if (k == 1 || k == 3) begin
                compared++;
                if (ifc2.prog_rdy !== (k == 3)) begin
                    mismatched++; $display("[TB] FAIL wait_timing_rdy k=%0d: got %b expected %b", k, ifc2.prog_rdy, k == 3);
                end
            end
            tick();
        end
        rd_exp2++;
        ifc2.memreq_val = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        logic [31:0] exp;
        prog2(16'h0000, 32'hA);
        prog2(16'h0004, 32'hB);
        ifc2.memreq_val = 1'b1; ifc2.memreq_addr = 16'h0000;
        sample();
        compared++;
        if (ifc2.memresp_wait !== 1'b1) begin
            mismatched++; $display("[TB] FAIL addr_change_first: got %b expected 1", ifc2.memresp_wait);
        end
        tick();
        ifc2.memreq_addr = 16'h0004;
        for (int k = 0; k < 3; k++) begin
            exp = (k < 2) ? 32'h0 : 32'hB;
            sample();
            compared++;
            if (ifc2.memresp_wait !== (k < 2) || ifc2.memresp_data !== exp) begin
                mismatched++;
                $display("[TB] FAIL addr_change k=%0d: got wait %b data %h expected wait %b data %h", k, ifc2.memresp_wait, ifc2.memresp_data, k < 2, exp);
            end
            tick();
        end
        rd_exp2++;
        ifc2.memreq_val = 1'b0;
        tick();
        ifc2.memreq_val = 1'b1; ifc2.memreq_addr = 16'h0000;
        tick();
        ifc2.memreq_val = 1'b0;
        tick();
        sample();
        compared += 2;
        if (ifc2.memresp_wait !== 1'b0) begin
            mismatched++; $display("[TB] FAIL abort_wait: got %b expected 0", ifc2.memresp_wait);
        end
        if (ifc2.memresp_data !== 32'h0) begin
            mismatched++; $display("[TB] FAIL abort_data: got %h expected 0", ifc2.memresp_data);
        end
        tick();
        test_rd_count("abort");
    endtask

    task automatic test_random_wait();
        logic [15:0] a;
        logic [15:0] last;
        logic [31:0] exp;
        bit          held;
        int          len;
        for (int i = 0; i < 8; i++) begin
            a = {7'($urandom_range(1, 2)), 7'($urandom_range(0, 127)), 2'b00};
            prog2(a, $urandom);
            addrs2.push_back(a);
        end
        held = 1'b0; last = '0;
        for (int i = 0; i < 14; i++) begin
            a = addrs2[$urandom_range(0, addrs2.size() - 1)];
            len = $urandom_range(1, 4);
            if (held && a == last) begin
                ifc2.memreq_val = 1'b0;
                tick();
            end
            ifc2.memreq_val = 1'b1; ifc2.memreq_addr = a;
            for (int k = 0; k < len; k++) begin
                exp = (k < 2) ? 32'h0 : model2[a[15:2]];
                sample();
                compared++;
                if (ifc2.memresp_wait !== (k < 2) || ifc2.memresp_data !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL rand2 @%h k=%0d: got wait %b data %h expected wait %b data %h", a, k, ifc2.memresp_wait, ifc2.memresp_data, k < 2, exp);
                end
                tick();
            end
            if (len >= 3) rd_exp2++;
            held = 1'b1; last = a;
            if ($urandom_range(0, 1) == 1) begin
                ifc2.memreq_val = 1'b0;
                held = 1'b0;
                tick();
            end
        end
        ifc2.memreq_val = 1'b0;
        tick();
        test_rd_count("rand2");
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp;
        ifc0.memreq_val = 1'b1; ifc0.memreq_addr = 16'h0800;
        sample();
        compared++;
        if (ifc0.memresp_data !== 32'hFFFF_FFFF) begin
            mismatched++; $display("[TB] FAIL oor_data: got %h expected ffffffff", ifc0.memresp_data);
        end
        rd_exp0++;
        tick();
        ifc0.memreq_val = 1'b0;
        sample();
        compared++;
        if (ifc0.addr_err !== 1'b1) begin
            mismatched++; $display("[TB] FAIL oor_err: got %b expected 1", ifc0.addr_err);
        end
        tick();
        prog0(16'h0800, 32'hDEAD_BEEF);
        ifc0.memreq_val = 1'b1; ifc0.memreq_addr = 16'h0000;
        tick(); tick();
        sample();
        compared += 2;
        if (ifc0.memresp_data !== model0[14'h0]) begin
            mismatched++; $display("[TB] FAIL oor_write_dropped: got %h expected %h", ifc0.memresp_data, model0[14'h0]);
        end
        if (ifc0.addr_err !== 1'b1) begin
            mismatched++; $display("[TB] FAIL oor_err_sticky: got %b expected 1", ifc0.addr_err);
        end
        rd_exp0++;
        tick();
        ifc0.memreq_val = 1'b0;
        ifc2.memreq_val = 1'b1; ifc2.memreq_addr = 16'h0602;
        for (int k = 0; k < 3; k++) begin
            exp = (k < 2) ? 32'h0 : model2[14'h180];
            sample();
            compared++;
            if (ifc2.memresp_wait !== (k < 2) || ifc2.memresp_data !== exp) begin
                mismatched++;
                $display("[TB] FAIL misaligned k=%0d: got wait %b data %h expected wait %b data %h", k, ifc2.memresp_wait, ifc2.memresp_data, k < 2, exp);
            end
            tick();
        end
        rd_exp2++;
        ifc2.memreq_val = 1'b0;
        sample();
        compared++;
        if (ifc2.addr_err !== 1'b1) begin
            mismatched++; $display("[TB] FAIL misaligned_err: got %b expected 1", ifc2.addr_err);
        end
        tick();
    endtask

    task automatic test_write_collision();
        ifc0.memreq_val = 1'b1; ifc0.memreq_addr = 16'h0004;
        ifc0.prog_val = 1'b1; ifc0.prog_addr = 16'h0004; ifc0.prog_data = 32'd7;
        sample();
        compared++;
        if (ifc0.memresp_data !== model0[14'h1]) begin
            mismatched++; $display("[TB] FAIL collision_old: got %h expected %h", ifc0.memresp_data, model0[14'h1]);
        end
        tick();
        model0[14'h1] = 32'd7;
        ifc0.prog_val = 1'b0;
        sample();
        compared++;
        if (ifc0.memresp_data !== 32'd7) begin
            mismatched++; $display("[TB] FAIL collision_new: got %h expected 7", ifc0.memresp_data);
        end
        rd_exp0++;
        tick();
        ifc0.memreq_val = 1'b0;
        ifc2.memreq_val = 1'b1; ifc2.memreq_addr = 16'h0600;
        tick();
        ifc2.prog_val = 1'b1; ifc2.prog_addr = 16'h0600; ifc2.prog_data = 32'd9;
        sample();
        compared++;
        if (ifc2.prog_rdy !== 1'b0) begin
            mismatched++; $display("[TB] FAIL wait_prog_rdy: got %b expected 0", ifc2.prog_rdy);
        end
        tick();
        ifc2.prog_val = 1'b0;
        sample();
        compared++;
        if (ifc2.memresp_wait !== 1'b0 || ifc2.memresp_data !== model2[14'h180]) begin
            mismatched++; $display("[TB] FAIL wait_write_blocked: got wait %b data %h expected wait 0 data %h", ifc2.memresp_wait, ifc2.memresp_data, model2[14'h180]);
        end
        rd_exp2++;
        tick();
        ifc2.memreq_val = 1'b0;
        tick();
        test_rd_count("collision");
    endtask

    task automatic test_reset_mid_wait();
        ifc2.memreq_val = 1'b1; ifc2.memreq_addr = 16'h0004;
        tick();
        #2 rst = 1'b1;
        #1;
        rd_exp0 = 0; rd_exp2 = 0;
        compared += 4;
        if (ifc2.memresp_wait !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_wait: got %b expected 0", ifc2.memresp_wait);
        end
        if (ifc2.memresp_data !== 32'h0) begin
            mismatched++; $display("[TB] FAIL rst_data: got %h expected 0", ifc2.memresp_data);
        end
        if (ifc2.addr_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_err2: got %b expected 0", ifc2.addr_err);
        end
        if (ifc0.addr_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_err0: got %b expected 0", ifc0.addr_err);
        end
        test_rd_count("rst");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            compared++;
            if (ifc2.memresp_wait !== (k < 2) || ifc2.memresp_data !== ((k < 2) ? 32'h0 : model2[14'h1])) begin
                mismatched++; $display("[TB] FAIL post_rst k=%0d: got wait %b data %h expected wait %b", k, ifc2.memresp_wait, ifc2.memresp_data, k < 2);
            end
            tick();
        end
        rd_exp2++;
        ifc2.memreq_val = 1'b0;
        ifc0.memreq_val = 1'b1; ifc0.memreq_addr = 16'h0004;
        sample();
        compared++;
        if (ifc0.memresp_data !== 32'd7) begin
            mismatched++; $display("[TB] FAIL array_kept: got %h expected 7", ifc0.memresp_data);
        end
        rd_exp0++;
        tick();
        ifc0.memreq_val = 1'b0;
        tick();
        test_rd_count("post_rst");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_random_zero_wait();
        test_wait_timing();
        test_addr_change();
        test_random_wait();
        test_out_of_range();
        test_write_collision();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
